// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if: requester handshakes, result channel and busy flag of
// the shared-multiplier controller. The slave modport is the controller side,
// the master modport is the requester/consumer side.
interface mult_share_ctrl_if;
  logic       req0_valid;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       req1_ready;
  logic       res_valid;
  logic [7:0] res_pro;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output res_valid, res_pro, res_id,
    input  res_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  res_valid, res_pro, res_id,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one 4x4 unsigned array multiplier between two
// requesters. IDLE grants one requester and registers its operands, CALC
// captures the product, HOLD presents it until the consumer takes it.
// Build option: define MULT_SHARE_RR_EN for round-robin tie-breaking;
// otherwise requester 0 always wins ties and the priority pointer is constant 0.

// Unsigned 4x4 array multiplier: four shifted partial-product rows summed.
module mult4x4_array (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [7:0] pp0, pp1, pp2, pp3;

  // Partial-product rows gated by each multiplier bit, then summed
  always_comb begin
    pp0 = b_i[0] ? {4'b0000, a_i}        : '0;
    pp1 = b_i[1] ? {3'b000, a_i, 1'b0}   : '0;
    pp2 = b_i[2] ? {2'b00, a_i, 2'b00}   : '0;
    pp3 = b_i[3] ? {1'b0, a_i, 3'b000}   : '0;
    p_o = pp0 + pp1 + pp2 + pp3;
  end
endmodule

module mult_share_ctrl (
  input  logic                clk,
  input  logic                rst,
  mult_share_ctrl_if.slave    bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic       op_id_q, op_id_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_pro_q, res_pro_d;
  logic       res_id_q, res_id_d;

  logic       prio;
  logic       in_idle;
  logic       grant;
  logic       ready0, ready1;
  logic       hs0, hs1;
  logic       accept;
  logic [7:0] product;

  mult4x4_array u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (product)
  );

`ifdef MULT_SHARE_RR_EN
  logic prio_q, prio_d;

  // Priority pointer flips to the other requester after every grant
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = ~grant;
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  // Grant: a lone valid requester always wins; ties go to prio
  always_comb begin
    in_idle = (state_q == ST_IDLE);
    if (bus.req0_valid && bus.req1_valid) grant = prio;
    else                                  grant = bus.req1_valid;
    ready0 = in_idle && !grant && bus.req0_valid && !rst;
    ready1 = in_idle &&  grant && bus.req1_valid && !rst;
    hs0    = bus.req0_valid && ready0;
    hs1    = bus.req1_valid && ready1;
    accept = hs0 || hs1;
  end

  // Next-state and datapath-register updates for IDLE/CALC/HOLD
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    res_valid_d = res_valid_q;
    res_pro_d   = res_pro_q;
    res_id_d    = res_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_a_d  = hs1 ? bus.req1_a : bus.req0_a;
          op_b_d  = hs1 ? bus.req1_b : bus.req0_b;
          op_id_d = hs1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_pro_d   = product;
        res_id_d    = op_id_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_pro_q   <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      res_valid_q <= res_valid_d;
      res_pro_q   <= res_pro_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_pro    = res_pro_q;
  assign bus.res_id     = res_id_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing and arbitration controller that shares one 4x4 unsigned array multiplier between two requesters. It accepts operand pairs over valid/ready handshakes and registers the operands into the multiplier. It captures the 8-bit product in an output register and presents it to a single consumer, tagged with the requester ID. It sits between the two operand producers and the multiplier datapath, which it instantiates unchanged.

## Interface
- No parameters; operand width is fixed at 4, product width at 8.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  4  requester 0 multiplicand
- req0_b  in  4  requester 0 multiplier
- req0_ready  out  1  requester 0 pair accepted this cycle
- req1_valid  in  1  requester 1 has an operand pair
- req1_a  in  4  requester 1 multiplicand
- req1_b  in  4  requester 1 multiplier
- req1_ready  out  1  requester 1 pair accepted this cycle
- res_valid  out  1  product available
- res_pro  out  8  unsigned product
- res_id  out  1  requester that issued the product
- res_ready  in  1  consumer accepts product
- busy  out  1  high whenever state is not IDLE

## Operation
- Arithmetic: unsigned 4x4 -> 8 bit. No overflow is possible (max 15*15 = 225 = 0xE1).
- FSM has three states: IDLE, CALC, HOLD.
- IDLE:
  - The grant is computed combinationally from req0_valid, req1_valid and the priority pointer prio.
  - If only one request is valid, that requester is granted. If both are valid, requester prio is granted.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid && !rst.
  - On a handshake (valid & ready), the controller latches a, b and the ID into op_a, op_b and op_id, updates prio to the inverse of the granted ID, and moves to CALC.
- CALC: op_a/op_b drive the multiplier. At the edge, res_pro <= product, res_id <= op_id, res_valid <= 1, and the state moves to HOLD.
- HOLD: res_valid, res_pro and res_id are held stable. When res_valid && res_ready, res_valid <= 0 and the state moves to IDLE. res_pro and res_id keep their last value.
- Requesters must hold valid, a and b stable until ready. Deasserting valid before ready is legal; the pair is simply not taken.
- No new request is accepted in CALC or HOLD. Both ready outputs are low there.
- reqN_ready depends combinationally on reqN_valid and on the other requester's valid. Requesters must not derive valid from ready.

## Timing
- Reset values: state IDLE, prio 0, res_valid 0, res_pro 0x00, res_id 0, busy 0, op regs 0. Both ready outputs are 0 while rst is high.
- Latency: a handshake at edge N gives res_valid=1 after edge N+1, in the cycle following CALC.
- Minimum issue interval is 3 cycles: accept, CALC, HOLD with res_ready=1. The next accept can occur in the cycle after HOLD exits.
- Backpressure: HOLD lasts indefinitely while res_ready=0. No state or output changes.
- Simultaneous requests are resolved by prio. A single valid request is never blocked by prio.
- Reset asserted in any state:
  - The in-flight operation is discarded and no result is emitted.
  - All registers return to reset values at that edge.
  - The first possible accept is in the first cycle with rst low.
- res_ready asserted while res_valid=0 has no effect.

## Configuration
- MULT_SHARE_RR_EN defined: round-robin arbitration as described. prio toggles to the other requester after every grant.
- MULT_SHARE_RR_EN undefined: fixed priority with requester 0 always winning ties. prio is not implemented and reads as constant 0. Requester 1 is granted only when req0_valid=0.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> res_valid=0, res_pro=0x00, res_id=0, busy=0, req0_ready=req1_ready=0 throughout.
- Single request: req0 a=3, b=5, res_ready=1 -> req0_ready high for one cycle, then res_valid=1 with res_pro=0x0F and res_id=0 one cycle after CALC, then busy falls.
- Extremes: req1 a=0xF, b=0xF gives res_pro=0xE1 and res_id=1. a=0x0, b=0xA gives 0x00. An exhaustive 256-pair sweep on req0 matches a*b.
- Contention: both valid continuously with res_ready=1:
  - RR_EN defined: res_id sequence is 0,1,0,1.
  - RR_EN undefined: res_id sequence is 0,0,0,0.
- Backpressure: res_ready=0 for 5 cycles in HOLD -> res_valid, res_pro and res_id stay stable and both readys stay low. Raising res_ready returns the FSM to IDLE on the next edge.
- Mid-operation reset: rst pulsed in CALC after accepting a=7, b=9 -> res_valid never rises, prio=0, and the next request completes normally.
